// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scancode receiver: FSM states, clock filter length, parity helper.
// No logic or timing here; users import it with ps2_pkg::*.
package ps2_pkg;

  localparam int FILTER_LEN = 8;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_e;

  // Parity bit that makes data plus parity carry an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~(^d);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: head is visible the cycle after a push into an empty FIFO.
// A push while full is dropped with an overflow pulse, unless a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             overflow_q;
  logic             do_push, do_pop, not_empty, full;

  assign not_empty = (count_q != '0);
  assign full      = (count_q == (AW+1)'(DEPTH));
  assign do_pop    = pop_i && not_empty;
  assign do_push   = push_i && (!full || do_pop);

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= push_i && !do_push;
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_o     = not_empty ? mem_q[rd_ptr_q] : '0;
  assign valid_o    = not_empty;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: synchronise, glitch-filter, deserialise 11-bit frames into a scancode FIFO.
// Byte pushed the cycle after the stop-bit sample; code_valid/code_ready pop; full FIFO drops new bytes.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int CLK_MHZ    = 25,
  parameter int TIMEOUT_US = 2000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps2clk,
  input  logic                          ps2data,
  output logic [7:0]                    code,
  output logic                          code_valid,
  input  logic                          code_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int unsigned WDOG_LIMIT = CLK_MHZ * TIMEOUT_US;
  localparam int          WD_W       = $clog2(WDOG_LIMIT + 1);
  localparam int          FC_W       = $clog2(FILTER_LEN);

  logic              ps2clk_s1_q, ps2clk_s2_q, ps2data_s1_q, ps2data_s2_q;
  logic              filt_q;
  logic [FC_W-1:0]   filt_cnt_q;
  logic              filt_flip, sample_evt;

  state_e            state_q;
  logic [2:0]        bit_cnt_q;
  logic [7:0]        shift_q;
  logic              par_ok_q;
  logic [WD_W-1:0]   wdog_q;
  logic              wdog_expired;
  logic              push_q;
  logic [7:0]        push_dat_q;
  logic              parity_err_q, frame_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ps2clk_s1_q  <= 1'b1;
      ps2clk_s2_q  <= 1'b1;
      ps2data_s1_q <= 1'b1;
      ps2data_s2_q <= 1'b1;
    end else begin
      ps2clk_s1_q  <= ps2clk;
      ps2clk_s2_q  <= ps2clk_s1_q;
      ps2data_s1_q <= ps2data;
      ps2data_s2_q <= ps2data_s1_q;
    end
  end

  // The filtered level flips on the FILTER_LEN-th consecutive differing sample.
  assign filt_flip  = (ps2clk_s2_q != filt_q) && (filt_cnt_q == FC_W'(FILTER_LEN - 1));
  assign sample_evt = filt_flip && filt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
    end else if (ps2clk_s2_q == filt_q) begin
      filt_cnt_q <= '0;
    end else if (filt_flip) begin
      filt_q     <= ps2clk_s2_q;
      filt_cnt_q <= '0;
    end else begin
      filt_cnt_q <= filt_cnt_q + FC_W'(1);
    end
  end

  assign wdog_expired = (state_q != IDLE) && !sample_evt && (wdog_q == WD_W'(WDOG_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_ok_q     <= 1'b0;
      wdog_q       <= '0;
      push_q       <= 1'b0;
      push_dat_q   <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      push_q       <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;

      if (state_q == IDLE || sample_evt) wdog_q <= '0;
      else                               wdog_q <= wdog_q + WD_W'(1);

      if (wdog_expired) begin
        frame_err_q <= 1'b1;
        state_q     <= IDLE;
        bit_cnt_q   <= '0;
        wdog_q      <= '0;
      end else if (sample_evt) begin
        case (state_q)
          IDLE: begin
            if (!ps2data_s2_q) begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
            end
          end
          DATA: begin
            shift_q   <= {ps2data_s2_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            par_ok_q <= (ps2data_s2_q == odd_parity(shift_q));
            state_q  <= STOP;
          end
          STOP: begin
            if (!ps2data_s2_q) begin
              frame_err_q <= 1'b1;
            end else if (!par_ok_q) begin
              parity_err_q <= 1'b1;
            end else begin
              push_q     <= 1'b1;
              push_dat_q <= shift_q;
            end
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push_q),
    .push_dat_i (push_dat_q),
    .pop_i      (code_ready),
    .head_o     (code),
    .valid_o    (code_valid),
    .count_o    (fifo_count),
    .overflow_o (overflow)
  );

  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: bit-level PS/2 frame driver, frame-outcome model with an expected-byte queue.
// Clock rate and timeout are scaled down so every scenario fits a short run.
module tb_ps2_scancode_rx;

  localparam int CLK_MHZ    = 4;
  localparam int TIMEOUT_US = 50;
  localparam int DEPTH      = 8;
  localparam int LIMIT      = CLK_MHZ * TIMEOUT_US;
  localparam int H          = 24;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2clk = 1'b1;
  logic       ps2data = 1'b1;
  logic       code_ready = 1'b0;
  logic [7:0] code;
  logic       code_valid;
  logic [3:0] fifo_count;
  logic       parity_err, frame_err, overflow;

  int total = 0, bad = 0;
  int cyc = 0, last_fall = 0, ferr_cyc = 0;
  int n_perr = 0, n_ferr = 0, n_ovf = 0, n_valid = 0;
  int e_perr = 0, e_ferr = 0, e_ovf = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  bit rdy_rand = 1'b0, rdy_fix = 1'b0, glitch = 1'b0;

  ps2_scancode_rx #(
    .CLK_MHZ    (CLK_MHZ),
    .TIMEOUT_US (TIMEOUT_US),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2clk     (ps2clk),
    .ps2data    (ps2data),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .fifo_count (fifo_count),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    #1 code_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
  end

  always @(negedge clk) begin
    if (parity_err) n_perr++;
    if (frame_err) begin
      n_ferr++;
      ferr_cyc = cyc;
    end
    if (overflow) n_ovf++;
    if (code_valid) n_valid++;
    if (code_valid && code_ready) got_q.push_back(code);
  end

  // Frame outcome from the protocol rules: bad stop beats bad parity; a good byte is kept only if there is room.
  function automatic void model_frame(input logic [7:0] d, input logic par, input logic stop);
    if (!stop) e_ferr++;
    else if ((^{d, par}) != 1'b1) e_perr++;
    else if (exp_q.size() - got_q.size() >= DEPTH) e_ovf++;
    else exp_q.push_back(d);
  endfunction

  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2data = b;
    repeat (H/2) @(negedge clk);
    ps2clk = 1'b0;
    last_fall = cyc;
    repeat (H) @(negedge clk);
    ps2clk = 1'b1;
    repeat (H/2) @(negedge clk);
    if (glitch) begin
      ps2clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
    ps2data = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (code !== 8'h00) begin bad++; $display("FAIL reset_code got=%h want=00", code); end
    total++; if (code_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", code_valid); end
    total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
    total++; if ({parity_err, frame_err, overflow} !== 3'b000) begin
      bad++; $display("FAIL reset_errs got=%b want=000", {parity_err, frame_err, overflow});
    end
    reset = 1'b0;
    repeat (20) @(negedge clk);
    total++; if (n_perr + n_ferr + n_ovf + n_valid != 0) begin
      bad++; $display("FAIL idle_quiet got=%0d events want=0", n_perr + n_ferr + n_ovf + n_valid);
    end
  endtask

  task automatic test_basic();
    int v0;
    rdy_fix = 1'b1;
    v0 = n_valid;
    model_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    total++; if (got_q.size() != exp_q.size() || got_q[$] !== 8'h1C) begin
      bad++; $display("FAIL basic_code got=%0d bytes last=%h want=%0d bytes last=1c", got_q.size(), got_q[$], exp_q.size());
    end
    total++; if (n_valid - v0 != 1) begin bad++; $display("FAIL basic_valid_len got=%0d want=1", n_valid - v0); end
    total++; if (n_perr != e_perr || n_ferr != e_ferr) begin
      bad++; $display("FAIL basic_errs got=%0d/%0d want=%0d/%0d", n_perr, n_ferr, e_perr, e_ferr);
    end
  endtask

  task automatic test_parity();
    int v0;
    v0 = n_valid;
    model_frame(8'h1C, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b1, 1'b1);
    total++; if (n_perr != e_perr) begin bad++; $display("FAIL parity_err got=%0d want=%0d", n_perr, e_perr); end
    total++; if (n_valid != v0 || got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL parity_nopush got=%0d valid cycles want=0", n_valid - v0);
    end
  endtask

  task automatic test_frame_err();
    model_frame(8'hF0, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b1, 1'b0);
    total++; if (n_ferr != e_ferr || got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL stop_frame_err got=%0d/%0d want=%0d/%0d", n_ferr, got_q.size(), e_ferr, exp_q.size());
    end
    model_frame(8'h5A, 1'b1, 1'b1);
    send_frame(8'h5A, 1'b1, 1'b1);
    total++; if (got_q.size() != exp_q.size() || got_q[$] !== 8'h5A) begin
      bad++; $display("FAIL after_ferr_code got=%h want=5a", got_q[$]);
    end
  endtask

  task automatic test_timeout();
    int dt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(i & 1));
    repeat (LIMIT * 21 / 20 + 20) @(negedge clk);
    e_ferr++;
    dt = ferr_cyc - last_fall;
    total++; if (n_ferr != e_ferr) begin bad++; $display("FAIL timeout_pulse got=%0d want=%0d", n_ferr, e_ferr); end
    total++; if (dt < LIMIT || dt > LIMIT + 20) begin
      bad++; $display("FAIL timeout_time got=%0d cycles want=%0d..%0d", dt, LIMIT, LIMIT + 20);
    end
    model_frame(8'h12, 1'b1, 1'b1);
    send_frame(8'h12, 1'b1, 1'b1);
    total++; if (got_q.size() != exp_q.size() || got_q[$] !== 8'h12) begin
      bad++; $display("FAIL after_timeout_code got=%h want=12", got_q[$]);
    end
  endtask

  task automatic test_overflow();
    int base;
    logic [7:0] b;
    rdy_fix = 1'b0;
    repeat (4) @(negedge clk);
    base = exp_q.size();
    for (int i = 1; i <= 9; i++) begin
      b = 8'(i);
      model_frame(b, ~(^b), 1'b1);
      send_frame(b, ~(^b), 1'b1);
      if (i == 8) begin
        total++; if (fifo_count !== 4'd8 || n_ovf != e_ovf) begin
          bad++; $display("FAIL full_count got=%0d ovf=%0d want=8 ovf=%0d", fifo_count, n_ovf, e_ovf);
        end
      end
    end
    total++; if (n_ovf != e_ovf || e_ovf != 1) begin bad++; $display("FAIL overflow_pulse got=%0d want=1", n_ovf); end
    total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL overflow_count got=%0d want=8", fifo_count); end
    rdy_fix = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL drain_size got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    for (int i = base; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL drain_order got=%h want=%h", got_q[i], exp_q[i]); end
    end
    total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL drain_empty got=%0d want=0", fifo_count); end
  endtask

  task automatic test_glitch_reset();
    glitch = 1'b1;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    total++; if (n_perr != e_perr || n_ferr != e_ferr) begin
      bad++; $display("FAIL reset_midframe_errs got=%0d/%0d want=%0d/%0d", n_perr, n_ferr, e_perr, e_ferr);
    end
    model_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    glitch = 1'b0;
    total++; if (got_q.size() != exp_q.size() || got_q[$] !== 8'h1C) begin
      bad++; $display("FAIL glitch_code got=%h n=%0d want=1c n=%0d", got_q[$], got_q.size(), exp_q.size());
    end
    total++; if (n_perr != e_perr || n_ferr != e_ferr) begin
      bad++; $display("FAIL glitch_errs got=%0d/%0d want=%0d/%0d", n_perr, n_ferr, e_perr, e_ferr);
    end
  endtask

  task automatic test_random();
    int base;
    logic [7:0] d;
    logic par, stop;
    int kind;
    base = exp_q.size();
    rdy_rand = 1'b1;
    for (int n = 0; n < 12; n++) begin
      d    = 8'($urandom);
      kind = $urandom_range(0, 5);
      par  = ~(^d);
      stop = 1'b1;
      if (kind == 0) par = ~par;
      if (kind == 1) stop = 1'b0;
      model_frame(d, par, stop);
      send_frame(d, par, stop);
    end
    rdy_rand = 1'b0;
    rdy_fix  = 1'b1;
    repeat (10) @(negedge clk);
    total++; if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL rand_size got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    for (int i = base; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_code got=%h want=%h", got_q[i], exp_q[i]); end
    end
    total++; if (n_perr != e_perr || n_ferr != e_ferr || n_ovf != e_ovf) begin
      bad++; $display("FAIL rand_errs got=%0d/%0d/%0d want=%0d/%0d/%0d", n_perr, n_ferr, n_ovf, e_perr, e_ferr, e_ovf);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_frame_err();
    test_timeout();
    test_overflow();
    test_glitch_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
